pkg_delay_arbiter: RTL

PKG_DELAY_ARBITER -- requirements
Module: pkg_delay_arbiter

---
 rtl/pkg_delay_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pkg_delay_arbiter.sv
// Two-requester packet arbiter feeding a PkgDelay stage. Grants whole packets round-robin
// and applies delay configuration only between packets.
module pkg_delay_arbiter #(
  parameter int          DATA_W        = 512,
  parameter int          KEEP_W        = 64,
  parameter logic [31:0] DEFAULT_DELAY = 32'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in0_valid,
  output logic              io_in0_ready,
  input  logic [DATA_W-1:0] io_in0_bits_data,
  input  logic [KEEP_W-1:0] io_in0_bits_keep,
  input  logic              io_in0_bits_last,
  input  logic              io_in1_valid,
  output logic              io_in1_ready,
  input  logic [DATA_W-1:0] io_in1_bits_data,
  input  logic [KEEP_W-1:0] io_in1_bits_keep,
  input  logic              io_in1_bits_last,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_bits_data,
  output logic [KEEP_W-1:0] io_out_bits_keep,
  output logic              io_out_bits_last,
  input  logic              io_cfg_valid,
  input  logic [31:0]       io_cfg_delay,
  output logic [31:0]       io_delay_cycle,
  output logic              io_busy,
  output logic [1:0]        io_grant,
  output logic [31:0]       io_pkt_cnt0,
  output logic [31:0]       io_pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t      state;
  logic        last_gnt;   // 1: in1 was granted last, so in0 wins the next tie
  logic [31:0] pend_delay;
  logic        pend_vld;
  logic        done0, done1;

  assign done0 = (state == GRANT0) && io_in0_valid && io_out_ready && io_in0_bits_last;
  assign done1 = (state == GRANT1) && io_in1_valid && io_out_ready && io_in1_bits_last;

  always_comb begin
    io_out_valid     = 1'b0;
    io_out_bits_data = '0;
    io_out_bits_keep = '0;
    io_out_bits_last = 1'b0;
    io_in0_ready     = 1'b0;
    io_in1_ready     = 1'b0;
    io_grant         = 2'b00;
    io_busy          = 1'b0;
    case (state)
      GRANT0: begin
        io_out_valid     = io_in0_valid;
        io_out_bits_data = io_in0_bits_data;
        io_out_bits_keep = io_in0_bits_keep;
        io_out_bits_last = io_in0_bits_last;
        io_in0_ready     = io_out_ready;
        io_grant         = 2'b01;
        io_busy          = 1'b1;
      end
      GRANT1: begin
        io_out_valid     = io_in1_valid;
        io_out_bits_data = io_in1_bits_data;
        io_out_bits_keep = io_in1_bits_keep;
        io_out_bits_last = io_in1_bits_last;
        io_in1_ready     = io_out_ready;
        io_grant         = 2'b10;
        io_busy          = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (io_in0_valid && (!io_in1_valid || last_gnt)) state <= GRANT0;
          else if (io_in1_valid)                           state <= GRANT1;
        end
        GRANT0: if (done0) begin
          state    <= IDLE;
          last_gnt <= 1'b0;
        end
        GRANT1: if (done1) begin
          state    <= IDLE;
          last_gnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write in the same cycle as an apply stays pending, so it lands one IDLE edge later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_delay_cycle <= DEFAULT_DELAY;
      pend_delay     <= '0;
      pend_vld       <= 1'b0;
    end else begin
      if ((state == IDLE) && pend_vld) io_delay_cycle <= pend_delay;
      if (io_cfg_valid) begin
        pend_delay <= io_cfg_delay;
        pend_vld   <= 1'b1;
      end else if (state == IDLE) begin
        pend_vld   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_pkt_cnt0 <= '0;
      io_pkt_cnt1 <= '0;
    end else begin
      if (done0) io_pkt_cnt0 <= io_pkt_cnt0 + 32'd1;
      if (done1) io_pkt_cnt1 <= io_pkt_cnt1 + 32'd1;
    end
  end

endmodule
